// File: rtl/cmul_arbiter.sv
// Round-robin scheduler sharing one pipelined complex multiplier between two requesters.
// A tag pipeline tracks ownership of in-flight ops; credits keep the per-requester result FIFOs from overflowing.
module cmul_arbiter #(
  parameter int MULT_LAT   = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [48:0] req0_a,
  input  logic [47:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [48:0] req1_a,
  input  logic [47:0] req1_b,
  output logic [48:0] mul_element1,
  output logic [47:0] mul_element2,
  input  logic [48:0] mul_new1,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [48:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [48:0] rsp1_data,
  output logic        busy
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int STAGES = MULT_LAT + 1;

  logic [1:0]           valid, grant, elig, push, rsp_valid, rsp_ready;
  logic [1:0][48:0]     a, rsp_data;
  logic [1:0][47:0]     b;
  logic [1:0][CW-1:0]   credit;
  logic                 last_grant;
  logic [STAGES:1]      tag_vld, tag_id;

  assign valid     = {req1_valid, req0_valid};
  assign a         = {req1_a, req0_a};
  assign b         = {req1_b, req0_b};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  always_comb begin
    for (int i = 0; i < 2; i++) elig[i] = valid[i] & (credit[i] != '0);
    grant[0] = elig[0] & (~elig[1] | last_grant);
    grant[1] = elig[1] & (~elig[0] | ~last_grant);
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Stage 1 travels with the registered multiplier operands; the last stage lines up with mul_new1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_element1 <= '0;
      mul_element2 <= '0;
      tag_vld      <= '0;
      tag_id       <= '0;
      last_grant   <= 1'b1;
    end else begin
      mul_element1 <= grant[0] ? a[0] : grant[1] ? a[1] : '0;
      mul_element2 <= grant[0] ? b[0] : grant[1] ? b[1] : '0;
      tag_vld      <= {tag_vld[STAGES-1:1], |grant};
      tag_id       <= {tag_id[STAGES-1:1], grant[1]};
      if (|grant) last_grant <= grant[1];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_req
    logic [48:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, inflight;
    logic          pop;

    assign push[i]      = tag_vld[STAGES] & (tag_id[STAGES] == 1'(i));
    assign rsp_valid[i] = count != '0;
    assign rsp_data[i]  = mem[rd_ptr];
    assign pop          = rsp_valid[i] & rsp_ready[i];
    assign credit[i]    = CW'(FIFO_DEPTH) - inflight - count;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        inflight <= '0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr] <= mul_new1;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
        case ({grant[i], push[i]})
          2'b10:   inflight <= inflight + 1'b1;
          2'b01:   inflight <= inflight - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign busy       = (|tag_vld) | rsp_valid[0] | rsp_valid[1];
endmodule

// File: tb/tb_cmul_arbiter.sv
// Bench for cmul_arbiter: stub XOR multiplier, scoreboard queues per requester, directed scenarios.
module tb_cmul_arbiter;
  localparam int MULT_LAT   = 9;
  localparam int FIFO_DEPTH = 16;

  logic        clock = 1'b0, reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [48:0] req0_a = '0, req1_a = '0;
  logic [47:0] req0_b = '0, req1_b = '0;
  logic [48:0] mul_element1, mul_new1, rsp0_data, rsp1_data;
  logic [47:0] mul_element2;
  logic        rsp0_valid, rsp1_valid, busy;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  int n_chk = 0, n_err = 0;
  int acc0 = 0, acc1 = 0, pop0 = 0, pop1 = 0;
  logic [48:0] exp0[$], exp1[$];
  logic [48:0] stub [MULT_LAT];

  cmul_arbiter #(.MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_element1(mul_element1), .mul_element2(mul_element2), .mul_new1(mul_new1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Stub multiplier: not reset, so it keeps draining across a DUT reset.
  always @(posedge clock) begin
    stub[0] <= {mul_element1[48], mul_element1[47:0] ^ mul_element2};
    for (int k = 1; k < MULT_LAT; k++) stub[k] <= stub[k-1];
  end
  assign mul_new1 = stub[MULT_LAT-1];

  function automatic logic [48:0] cm(input logic [48:0] a, input logic [47:0] b);
    return {a[48], a[47:0] ^ b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_rand();
    req0_a = 49'({$urandom, $urandom});
    req0_b = 48'({$urandom, $urandom});
    req1_a = 49'({$urandom, $urandom});
    req1_b = 48'({$urandom, $urandom});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  task automatic single_op(input logic [48:0] a, input logic [47:0] b, input logic [48:0] exp_d);
    int n;
    req0_a = a; req0_b = b; req0_valid = 1'b1;
    @(negedge clock);
    chk("op_ready", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp0_valid && n < 20) begin tick(); n++; end
    chk("op_lat", n, 10);
    chk("op_data", rsp0_data, exp_d);
  endtask

  // Scoreboard: push on handshake, pop on response.
  always @(negedge clock) begin
    if (reset) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (req0_ready) chk("rdy0_vld", req0_valid, 1'b1);
      if (req1_ready) chk("rdy1_vld", req1_valid, 1'b1);
      if (req0_valid && req0_ready) begin
        exp0.push_back(cm(req0_a, req0_b)); acc0++;
        chk("credit0", exp0.size() <= FIFO_DEPTH, 1'b1);
      end
      if (req1_valid && req1_ready) begin
        exp1.push_back(cm(req1_a, req1_b)); acc1++;
        chk("credit1", exp1.size() <= FIFO_DEPTH, 1'b1);
      end
      if (rsp0_valid && rsp0_ready) begin
        pop0++;
        if (exp0.size() == 0) chk("rsp0_unexp", 1'b1, 1'b0);
        else chk("rsp0_data", rsp0_data, exp0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        pop1++;
        if (exp1.size() == 0) chk("rsp1_unexp", 1'b1, 1'b0);
        else chk("rsp1_data", rsp1_data, exp1.pop_front());
      end
    end
  end

  initial begin
    int a0, a1, p0, p1, q;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0", rsp0_valid, 1'b0);
    chk("rst_rsp1", rsp1_valid, 1'b0);
    chk("rst_e1", mul_element1, '0);
    chk("rst_e2", mul_element2, '0);
    chk("rst_d0", rsp0_data, '0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: single op
    single_op(49'h1_123456_ABCDEF, 48'hFFFFFF_000000, 49'h1_EDCBA9_ABCDEF);
    tick();
    chk("t1_busy", busy, 1'b0);

    // 2: contention, requester 0 won last so requester 1 goes first
    p0 = pop0; p1 = pop1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      @(negedge clock);
      chk("t2_g0", req0_ready, (i % 2) == 1);
      chk("t2_g1", req1_ready, (i % 2) == 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t2_drain");
    chk("t2_n0", pop0 - p0, 4);
    chk("t2_n1", pop1 - p1, 4);

    // 3: credit stall on requester 0 while requester 1 keeps issuing
    rsp0_ready = 1'b0;
    a0 = acc0; a1 = acc1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin drive_rand(); tick(); end
    chk("t3_acc0", acc0 - a0, 16);
    chk("t3_acc1", acc1 - a1, 24);
    req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin drive_rand(); tick(); end
    chk("t3_full", rsp0_valid, 1'b1);
    chk("t3_noacc", acc0 - a0, 16);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    a0 = acc0;
    for (int i = 0; i < 15; i++) begin drive_rand(); tick(); end
    chk("t3_one", acc0 - a0, 1);

    // 4: full FIFO drained while requester 0 keeps streaming
    for (int i = 0; i < 12; i++) begin drive_rand(); tick(); end
    a0 = acc0; p0 = pop0;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin drive_rand(); tick(); end
    req0_valid = 1'b0;
    drain("t4_drain");
    q = exp0.size();
    chk("t4_empty", q, 0);
    chk("t4_bal", pop0 - p0, (acc0 - a0) + 16);
    chk("t4_many", (acc0 - a0) >= 16, 1'b1);

    // 5: reset with ops in flight
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin drive_rand(); tick(); end
    req0_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rsp0_valid || rsp1_valid) q++;
      tick();
    end
    chk("t5_quiet", q, 0);
    single_op(49'h0_0F0F0F_123456, 48'h00FF00_FFFFFF, 49'h0_0FF00F_EDCBA9);
    tick();
    rsp0_ready = 1'b0;
    a0 = acc0;
    req0_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin drive_rand(); tick(); end
    req0_valid = 1'b0;
    chk("t5_credit", acc0 - a0, 16);
    rsp0_ready = 1'b1;
    drain("t5_drain");

    // 6: idle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_e1", mul_element1, '0);
      chk("t6_e2", mul_element2, '0);
      chk("t6_busy", busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
